// File: rtl/ps2_pkg.sv
// Shared PS/2 scan code set 2 constants and decoder state encoding.
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_e;

endpackage

// File: rtl/ps2_keyboard_if.sv
// PS/2 pin pair plus the key-event pulses handed to the downstream consumer.
interface ps2_keyboard_if #(parameter int SYMBOL_WIDTH = 7);

    logic                    ps2_clk;
    logic                    ps2_data;
    logic                    keyboard_left;
    logic                    keyboard_right;
    logic                    keyboard_backspace;
    logic [SYMBOL_WIDTH-1:0] keyboard_symbol;

    // master: the keyboard/pin side; slave: the decoder
    modport master (
        output ps2_clk, ps2_data,
        input  keyboard_left, keyboard_right, keyboard_backspace, keyboard_symbol
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keyboard_left, keyboard_right, keyboard_backspace, keyboard_symbol
    );

endinterface

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, shift register, idle timeout.
// Optional parity enforcement with PS2_KEYBOARD_PARITY_CHECK_EN.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       parity_err_o
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall;
    logic din;

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign din  = data_sync_q[1];

    always_comb begin
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bit_idx_q == 4'd0) begin
                if (!din) bit_idx_d = 4'd1;
            end else if (bit_idx_q <= 4'd8) begin
                shift_d   = {din, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 4'd1;
            end else if (bit_idx_q == 4'd9) begin
                parity_d  = din;
                bit_idx_d = bit_idx_q + 4'd1;
            end else begin
                bit_idx_d = 4'd0;
                if (din) begin
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
                    if (^{shift_q, parity_q}) valid_d = 1'b1;
                    else                      perr_d  = 1'b1;
`else
                    valid_d = 1'b1;
`endif
                end
            end
        end else if (bit_idx_q != 4'd0) begin
            if (tmo_q == TMO_LAST) begin
                bit_idx_d = 4'd0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

`ifndef PS2_KEYBOARD_PARITY_CHECK_EN
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            bit_idx_q   <= 4'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign byte_data_o  = shift_q;
    assign byte_valid_o = valid_q;
    assign parity_err_o = perr_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard decoder: turns received bytes into one-cycle key event pulses.
// Optional parity enforcement with PS2_KEYBOARD_PARITY_CHECK_EN (handled in ps2_receiver).
//   state    | meaning
//   IDLE     | no prefix pending
//   EXT      | E0 seen
//   BRK      | F0 seen
//   EXT_BRK  | E0 F0 seen, next byte is swallowed
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 2518
) (
    input  logic           clk,
    input  logic           rst,
    ps2_keyboard_if.slave  kbd
);

    localparam logic [1:0] S_IDLE    = DEC_IDLE;
    localparam logic [1:0] S_EXT     = DEC_EXT;
    localparam logic [1:0] S_BRK     = DEC_BRK;
    localparam logic [1:0] S_EXT_BRK = DEC_EXT_BRK;

    logic [7:0] bdata;
    logic       bvalid;
    logic       perr;

    ps2_receiver #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (kbd.ps2_clk),
        .ps2_data_i   (kbd.ps2_data),
        .byte_data_o  (bdata),
        .byte_valid_o (bvalid),
        .parity_err_o (perr)
    );

    function automatic logic [6:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [6:0] a;
        case (code)
            8'h45: a = shift ? 7'h29 : 7'h30;
            8'h16: a = shift ? 7'h00 : 7'h31;
            8'h1E: a = shift ? 7'h00 : 7'h32;
            8'h26: a = shift ? 7'h00 : 7'h33;
            8'h25: a = shift ? 7'h00 : 7'h34;
            8'h2E: a = shift ? 7'h00 : 7'h35;
            8'h36: a = shift ? 7'h5E : 7'h36;
            8'h3D: a = shift ? 7'h00 : 7'h37;
            8'h3E: a = shift ? 7'h2A : 7'h38;
            8'h46: a = shift ? 7'h28 : 7'h39;
            8'h55: a = shift ? 7'h2B : 7'h3D;
            8'h4E: a = 7'h2D;
            8'h49: a = 7'h2E;
            8'h41: a = 7'h2C;
            8'h4A: a = 7'h2F;
            8'h1C: a = 7'h61;  8'h32: a = 7'h62;  8'h21: a = 7'h63;  8'h23: a = 7'h64;
            8'h24: a = 7'h65;  8'h2B: a = 7'h66;  8'h34: a = 7'h67;  8'h33: a = 7'h68;
            8'h43: a = 7'h69;  8'h3B: a = 7'h6A;  8'h42: a = 7'h6B;  8'h4B: a = 7'h6C;
            8'h3A: a = 7'h6D;  8'h31: a = 7'h6E;  8'h44: a = 7'h6F;  8'h4D: a = 7'h70;
            8'h15: a = 7'h71;  8'h2D: a = 7'h72;  8'h1B: a = 7'h73;  8'h2C: a = 7'h74;
            8'h3C: a = 7'h75;  8'h2A: a = 7'h76;  8'h1D: a = 7'h77;  8'h22: a = 7'h78;
            8'h35: a = 7'h79;  8'h1A: a = 7'h7A;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

    logic [1:0]              state_q, state_d;
    logic                    lsh_q, lsh_d, rsh_q, rsh_d;
    logic                    left_q, left_d, right_q, right_d, bksp_q, bksp_d;
    logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;

    always_comb begin
        state_d = state_q;
        lsh_d   = lsh_q;
        rsh_d   = rsh_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        bksp_d  = 1'b0;
        sym_d   = '0;
        // a corrupted byte may have been a prefix, so never let it leave state behind
        if (perr) begin
            state_d = S_IDLE;
        end else if (bvalid) begin
            case (state_q)
                S_IDLE: begin
                    if (bdata == SC_EXT)         state_d = S_EXT;
                    else if (bdata == SC_BRK)    state_d = S_BRK;
                    else if (bdata == SC_LSHIFT) lsh_d   = 1'b1;
                    else if (bdata == SC_RSHIFT) rsh_d   = 1'b1;
                    else if (bdata == SC_BKSP)   bksp_d  = 1'b1;
                    else sym_d = SYMBOL_WIDTH'(scan_to_ascii(bdata, lsh_q | rsh_q));
                end
                S_EXT: begin
                    if (bdata == SC_BRK) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        left_d  = (bdata == SC_LEFT);
                        right_d = (bdata == SC_RIGHT);
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (bdata == SC_LSHIFT) lsh_d = 1'b0;
                    if (bdata == SC_RSHIFT) rsh_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            bksp_q  <= 1'b0;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
            left_q  <= left_d;
            right_q <= right_d;
            bksp_q  <= bksp_d;
            sym_q   <= sym_d;
        end
    end

    assign kbd.keyboard_left      = left_q;
    assign kbd.keyboard_right     = right_q;
    assign kbd.keyboard_backspace = bksp_q;
    assign kbd.keyboard_symbol    = sym_q;

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Upstream of `logic_`. Receives raw PS/2 keyboard traffic and decodes scan code set 2.
- Emits one-cycle key events on `keyboard_left`, `keyboard_right`, `keyboard_backspace` and `keyboard_symbol`, matching the pulse contract `logic_` consumes.
- Sits between the board PS/2 pins and `logic_` in the top level. The pixel clock domain is shared.

Parameters:
- SYMBOL_WIDTH, 7, width of the ASCII symbol output.
- TIMEOUT_CYCLES, 2518, idle clk cycles (~100 us at 25.175 MHz) after which a partial frame is discarded.

Ports:
- clk  input  1  system clock, 25.175 MHz.
- rst  input  1  asynchronous active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- keyboard_left  output  1  one-cycle pulse on Left arrow make.
- keyboard_right  output  1  one-cycle pulse on Right arrow make.
- keyboard_backspace  output  1  one-cycle pulse on Backspace make.
- keyboard_symbol  output  SYMBOL_WIDTH  ASCII code for one cycle on printable make; 0 otherwise.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All outputs 0.
  - Synchronisers load 1 (the PS/2 idle level).
  - Bit counter 0, decoder state IDLE, both shift flags 0, timeout counter 0.
- Synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flops. A falling edge is detected as previous synced clk = 1 and current synced clk = 0.
- Frame capture, on each falling edge:
  - Sample synced data; bit index 0..10 (start, d0..d7 LSB-first, odd parity, stop).
  - Start bit must be 0, otherwise ignore the edge and keep the bit index at 0.
  - At bit 10, the byte is valid if stop = 1. Assert internal `byte_valid` for 1 cycle, then reset the index to 0.
- Timeout: the counter increments while the index != 0 and there is no edge. At TIMEOUT_CYCLES-1 the index returns to 0 and the partial frame is dropped. The counter clears on every edge.
- Decoder FSM, advancing only on `byte_valid`:
  - IDLE: E0 -> EXT; F0 -> BRK; else make(code).
  - EXT: F0 -> EXT_BRK; else ext_make(code), -> IDLE.
  - BRK: break(code), -> IDLE.
  - EXT_BRK: -> IDLE, no action.
  - make: 12 or 59 sets the corresponding shift flag; 66 pulses backspace; a printable code pulses `keyboard_symbol`; any other code is ignored.
  - break: 12 or 59 clears the corresponding flag; all other codes are ignored.
  - ext_make: 6B pulses left, 74 pulses right; others are ignored.
- Shift is the OR of both flags.
- Printable map, unshifted:
  - 0-9 (45,16,1E,26,25,2E,36,3D,3E,46)
  - a-z (standard set 2)
  - '-' 4E, '=' 55, '.' 49, ',' 41, '/' 4A
- Printable map, shifted:
  - '(' 46, ')' 45, '*' 3E, '+' 55, '^' 36
  - letters stay lowercase; other digits are suppressed
- Output latency: outputs are registered and assert exactly 1 cycle after the `byte_valid` that completes the sequence. At most one output is active per cycle.
- Typematic repeats: extra make codes while a key is held produce extra pulses.
- Reset mid-frame or mid-sequence: all capture and decode state is discarded; no pulse.

Optional Feature:
- Macro: PS2_KEYBOARD_PARITY_CHECK_EN.
- Defined: at bit 10, additionally require XOR(d0..d7, parity) = 1. On mismatch, drop the byte and force the FSM to IDLE, so a corrupted E0 or F0 does not leak state.
- Undefined: the parity bit is captured but ignored.

Decomposition:
- Shared package `ps2_pkg`:
  - scan code constants (E0, F0, 66, 6B, 74, 12, 59)
  - decoder state enum (IDLE, EXT, BRK, EXT_BRK)
  - frame length 11
- One sub-module, `ps2_receiver`: synchronisers, edge detect, shift register, timeout. Its outputs are `byte_data[7:0]` and `byte_valid`.
- The decoder and scan-code-to-ASCII ROM stay in `ps2_keyboard`.

Test Plan:
- Reset, then frame 16 (code for '1', correct parity) -> `keyboard_symbol` = 0x31 for exactly 1 cycle, 1 cycle after the stop-bit edge; no other outputs assert.
- Sequence 12, 46, F0 46, F0 12 -> one pulse of 0x28 '('; the shift flag is clear afterwards; a following 46 gives 0x39 '9'.
- Sequences E0 6B, then E0 F0 6B -> one `keyboard_left` pulse only. E0 74 -> one `keyboard_right` pulse. 66 -> one `keyboard_backspace` pulse.
- Send 6 bits of a frame, idle 2600 cycles, then a full frame 1C -> only 0x61 'a' is emitted; the partial frame is dropped.
- With PS2_KEYBOARD_PARITY_CHECK_EN defined: send E0 with bad parity, then 6B -> no left pulse and no symbol (6B is unmapped in IDLE). Without the macro, the same stimulus gives a `keyboard_left` pulse.
- Assert `rst` after bit 5 of F0, release, then send 1C -> 0x61 is emitted, since the break state was not retained.
